lsu_bus_if: RTL and testbench

- Parametrised load/store unit between the CPU core and the data bridge.
- Replaces the core's direct, single-cycle, word-only Bus_addr/Bus_wdata/Bus_wen path.
- Adds byte/half/word(/dword) accesses, byte enables, sign/zero extension, alignment checking, a variable-latency bus handshake and a bus timeout.
- The core holds its request stable while lsu_stall is high.

---
 rtl/lsu_bus_if.sv | 214 +++++++++++++++++++++
 tb/tb_lsu_bus_if.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_if.sv
// Load/store unit between the core and the data bridge: sized accesses with byte
// enables, alignment checking, load extension and a bus handshake with timeout.
module lsu_bus_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  lsu_stall,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  Bus_req,
  output logic [ADDR_W-1:0]     Bus_addr,
  output logic                  Bus_wen,
  output logic [DATA_W/8-1:0]   Bus_be,
  output logic [DATA_W-1:0]     Bus_wdata,
  input  logic                  Bus_ack,
  input  logic [DATA_W-1:0]     Bus_rdata
);

  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUS, DONE, ERR} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              bus_req_q, bus_req_d;
  logic              wen_q, wen_d;
  logic [NB-1:0]     be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [LB-1:0]     lane_q, lane_d;

  // Request decode
  logic              misaligned, size_ok;
  logic [LB-1:0]     req_lane;
  logic [NB-1:0]     be_req;
  logic [DATA_W-1:0] wdata_rep;

  assign req_lane = req_addr[LB-1:0];
  assign size_ok  = (req_size != 2'd3) || (DATA_W == 64);

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = |req_addr[1:0];
      default: misaligned = |req_addr[2:0];
    endcase
  end

  always_comb begin
    be_req = '0;
    for (int b = 0; b < NB; b++)
      if (b >= int'(req_lane) && b < int'(req_lane) + (1 << req_size)) be_req[b] = 1'b1;
  end

  always_comb begin
    wdata_rep = req_wdata;
    case (req_size)
      2'd0:    wdata_rep = {NB{req_wdata[7:0]}};
      2'd1:    wdata_rep = {(NB/2){req_wdata[15:0]}};
      2'd2:    wdata_rep = {(DATA_W/32){req_wdata[31:0]}};
      default: wdata_rep = req_wdata;
    endcase
  end

  // Load data: align the addressed bytes to bit 0, then extend from the access size
  logic [DATA_W-1:0] shifted, mask, ld_ext;
  logic              sbit;
  int                nbytes;

  always_comb begin
    shifted = Bus_rdata >> {lane_q, 3'b000};
    nbytes  = 1 << size_q;
    mask    = '0;
    sbit    = 1'b0;
    for (int b = 0; b < NB; b++)
      if (b < nbytes) begin
        mask[8*b +: 8] = 8'hFF;
        sbit           = shifted[8*b+7];
      end
    ld_ext = shifted & mask;
    if (!uns_q && sbit) ld_ext = ld_ext | ~mask;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    wen_d       = wen_q;
    be_d        = be_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    lane_d      = lane_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (!size_ok || misaligned) begin
            state_d     = ERR;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d   = BUS;
            cnt_d     = '0;
            bus_req_d = 1'b1;
            wen_d     = req_we;
            be_d      = be_req;
            addr_d    = {req_addr[ADDR_W-1:LB], {LB{1'b0}}};
            wdata_d   = wdata_rep;
            we_d      = req_we;
            size_d    = req_size;
            uns_d     = req_unsigned;
            lane_d    = req_lane;
          end
        end
      end
      BUS: begin
        // Ack is checked first so an ack on the final allowed cycle still completes
        if (Bus_ack) begin
          state_d     = DONE;
          bus_req_d   = 1'b0;
          wen_d       = 1'b0;
          be_d        = '0;
          cnt_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? '0 : ld_ext;
        end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
          state_d     = ERR;
          bus_req_d   = 1'b0;
          wen_d       = 1'b0;
          be_d        = '0;
          cnt_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      wen_q       <= 1'b0;
      be_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      we_q        <= 1'b0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      lane_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      wen_q       <= wen_d;
      be_q        <= be_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      lane_q      <= lane_d;
    end
  end

  assign lsu_stall = req_valid & ~rsp_valid_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign Bus_req   = bus_req_q;
  assign Bus_addr  = addr_q;
  assign Bus_wen   = wen_q;
  assign Bus_be    = be_q;
  assign Bus_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_bus_if.sv
// Bench for lsu_bus_if (32-bit bus, TIMEOUT=8): transaction-level model drives a
// per-cycle expectation checked every negedge, plus literal checks of the model.
module tb_lsu_bus_if;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        lsu_stall, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        Bus_req, Bus_wen, Bus_ack;
  logic [31:0] Bus_addr, Bus_wdata, Bus_rdata;
  logic [3:0]  Bus_be;

  lsu_bus_if #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO)) dut (
    .cpu_clk(clk), .cpu_rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .lsu_stall(lsu_stall), .rsp_valid(rsp_valid),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .Bus_req(Bus_req),
    .Bus_addr(Bus_addr), .Bus_wen(Bus_wen), .Bus_be(Bus_be),
    .Bus_wdata(Bus_wdata), .Bus_ack(Bus_ack), .Bus_rdata(Bus_rdata));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Current-cycle expectations, written by the stimulus just after each posedge
  logic        chk_en = 1'b0, chk_zero = 1'b0;
  logic        exp_stall, exp_req, exp_rsp, exp_err, exp_wen;
  logic [31:0] exp_rdata, exp_addr, exp_wdata;
  logic [3:0]  exp_be;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("lsu_stall", lsu_stall, exp_stall);
      chk("Bus_req", Bus_req, exp_req);
      chk("rsp_valid", rsp_valid, exp_rsp);
      if (exp_req) begin
        chk("Bus_addr", Bus_addr, exp_addr);
        chk("Bus_be", Bus_be, exp_be);
        chk("Bus_wen", Bus_wen, exp_wen);
        if (exp_wen) chk("Bus_wdata", Bus_wdata, exp_wdata);
      end
      if (exp_rsp) begin
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_rdata", rsp_rdata, exp_rdata);
      end
      if (chk_zero) begin
        chk("zero_wen", Bus_wen, 0);
        chk("zero_be", Bus_be, 0);
        chk("zero_addr", Bus_addr, 0);
        chk("zero_wdata", Bus_wdata, 0);
        chk("zero_err", rsp_err, 0);
        chk("zero_rdata", rsp_rdata, 0);
      end
    end
  end

  task automatic set_idle();
    exp_stall = 1'b0; exp_req = 1'b0; exp_rsp = 1'b0; exp_err = 1'b0;
    exp_wen = 1'b0; exp_rdata = '0; exp_addr = '0; exp_wdata = '0; exp_be = '0;
  endtask

  // d = index of the bus cycle carrying Bus_ack (0 = zero-wait), -1 = never acked.
  // Stray acks in the request cycle and the completion cycle must be ignored.
  task automatic run_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int d, input logic [31:0] rd,
                         output logic [31:0] g_rdata, output logic [3:0] g_be,
                         output logic [31:0] g_addr, output logic [31:0] g_wdata,
                         output logic g_wen, output logic g_err,
                         output int g_rsp_cyc, output int g_req_cyc, output int g_stall_cyc);
    int n, lane, rc, last_bus;
    logic err;
    logic [63:0] v, span;
    logic [31:0] m_rdata, m_wdata;
    logic [3:0] m_be;
    n    = 1 << sz;
    lane = int'(addr % 4);
    err  = (sz == 2'd3) || (addr % n != 0);
    if (!err) begin
      span = 64'd1 << (8 * n);
      v = ({32'd0, rd} >> (8 * lane)) % span;
      if (!uns && v >= span / 2) v = v - span;
      m_rdata = v[31:0];
      for (int b = 0; b < 4; b++) m_wdata[8*b +: 8] = wd[8*(b % n) +: 8];
      m_be = 4'(((1 << n) - 1) << lane);
    end else begin
      m_rdata = '0; m_wdata = '0; m_be = '0;
    end
    last_bus = (d < 0) ? TO : 1 + d;
    rc = err ? 1 : last_bus + 1;
    g_rdata = 'x; g_be = '0; g_addr = '0; g_wdata = '0; g_wen = 1'b0; g_err = 1'b0;
    g_rsp_cyc = -1; g_req_cyc = 0; g_stall_cyc = 0;
    for (int c = 0; c <= rc; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = addr; req_wdata = wd;
      Bus_ack   = (c == 0) || (c == rc) || (!err && d >= 0 && c == 1 + d);
      Bus_rdata = (!err && d >= 0 && c == 1 + d) ? rd : 32'hA5A5_0000 + c;
      exp_stall = (c < rc);
      exp_req   = !err && c >= 1 && c <= last_bus;
      exp_rsp   = (c == rc);
      exp_err   = err || d < 0;
      exp_rdata = (we || err || d < 0) ? 32'h0 : m_rdata;
      exp_addr  = addr & ~32'h3;
      exp_be    = m_be;
      exp_wen   = we;
      exp_wdata = m_wdata;
      chk_en    = 1'b1;
      @(negedge clk);
      if (Bus_req) begin
        if (g_req_cyc == 0) begin
          g_be = Bus_be; g_addr = Bus_addr; g_wdata = Bus_wdata; g_wen = Bus_wen;
        end
        g_req_cyc++;
      end
      if (lsu_stall) g_stall_cyc++;
      if (rsp_valid && g_rsp_cyc < 0) begin
        g_rsp_cyc = c; g_rdata = rsp_rdata; g_err = rsp_err;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0; Bus_ack = 1'b0;
    set_idle();
  endtask

  logic [31:0] g_rdata, g_addr, g_wdata;
  logic [3:0]  g_be;
  logic        g_wen, g_err;
  int          g_rsp, g_req, g_stall;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; Bus_ack = 1'b0; Bus_rdata = '0;
    set_idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; chk_zero = 1'b1; chk_en = 1'b1;
    @(posedge clk); #1 chk_zero = 1'b0;

    // lb / lbu at 0x13, zero-wait
    run_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0, 32'h80FF7F01,
            g_rdata, g_be, g_addr, g_wdata, g_wen, g_err, g_rsp, g_req, g_stall);
    chk("t1_rdata", g_rdata, 32'hFFFFFF80);
    chk("t1_be", g_be, 4'b1000);
    chk("t1_addr", g_addr, 32'h10);
    chk("t1_wen", g_wen, 1'b0);
    chk("t1_lat", g_rsp, 2);
    run_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0, 32'h80FF7F01,
            g_rdata, g_be, g_addr, g_wdata, g_wen, g_err, g_rsp, g_req, g_stall);
    chk("t1u_rdata", g_rdata, 32'h00000080);

    // sh at 0x2
    run_req(1'b1, 2'd1, 1'b0, 32'h2, 32'h0000ABCD, 0, 32'hFFFFFFFF,
            g_rdata, g_be, g_addr, g_wdata, g_wen, g_err, g_rsp, g_req, g_stall);
    chk("t2_wen", g_wen, 1'b1);
    chk("t2_be", g_be, 4'b1100);
    chk("t2_wdata", g_wdata, 32'hABCDABCD);
    chk("t2_rdata", g_rdata, 32'h0);

    // misaligned lw
    run_req(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 0, 32'h0,
            g_rdata, g_be, g_addr, g_wdata, g_wen, g_err, g_rsp, g_req, g_stall);
    chk("t3_lat", g_rsp, 1);
    chk("t3_err", g_err, 1'b1);
    chk("t3_reqcyc", g_req, 0);
    chk("t3_stall", g_stall, 1);

    // lh at 0x4 with three wait cycles
    run_req(1'b0, 2'd1, 1'b0, 32'h4, 32'h0, 3, 32'h00008001,
            g_rdata, g_be, g_addr, g_wdata, g_wen, g_err, g_rsp, g_req, g_stall);
    chk("t4_be", g_be, 4'b0011);
    chk("t4_reqcyc", g_req, 4);
    chk("t4_stall", g_stall, 5);
    chk("t4_lat", g_rsp, 5);
    chk("t4_rdata", g_rdata, 32'hFFFF8001);

    // timeout, then a fresh request
    run_req(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, -1, 32'h0,
            g_rdata, g_be, g_addr, g_wdata, g_wen, g_err, g_rsp, g_req, g_stall);
    chk("t5_reqcyc", g_req, 8);
    chk("t5_lat", g_rsp, 9);
    chk("t5_err", g_err, 1'b1);
    run_req(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 0, 32'hCAFEF00D,
            g_rdata, g_be, g_addr, g_wdata, g_wen, g_err, g_rsp, g_req, g_stall);
    chk("t5b_rdata", g_rdata, 32'hCAFEF00D);

    // ack on the last cycle before timeout wins
    run_req(1'b0, 2'd1, 1'b1, 32'h2, 32'h0, 7, 32'h9876F00F,
            g_rdata, g_be, g_addr, g_wdata, g_wen, g_err, g_rsp, g_req, g_stall);
    chk("tedge_err", g_err, 1'b0);
    chk("tedge_rdata", g_rdata, 32'h00009876);
    chk("tedge_lat", g_rsp, 9);

    // sb, illegal dword, lw with one wait
    run_req(1'b1, 2'd0, 1'b0, 32'h1, 32'h123456C3, 0, 32'h0,
            g_rdata, g_be, g_addr, g_wdata, g_wen, g_err, g_rsp, g_req, g_stall);
    chk("sb_be", g_be, 4'b0010);
    chk("sb_wdata", g_wdata, 32'hC3C3C3C3);
    run_req(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 0, 32'h0,
            g_rdata, g_be, g_addr, g_wdata, g_wen, g_err, g_rsp, g_req, g_stall);
    chk("ld_err", g_err, 1'b1);
    run_req(1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 1, 32'h8000_0001,
            g_rdata, g_be, g_addr, g_wdata, g_wen, g_err, g_rsp, g_req, g_stall);
    chk("lw_rdata", g_rdata, 32'h80000001);

    // reset while a lw is on the bus, ack arrives afterwards
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h0; exp_stall = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; exp_req = 1'b1; exp_addr = 32'h0; exp_be = 4'hF; exp_wen = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0; Bus_ack = 1'b1; Bus_rdata = 32'h11111111;
    set_idle(); chk_zero = 1'b1;
    @(posedge clk); #1;
    Bus_ack = 1'b0;
    @(posedge clk); #1;
    chk_zero = 1'b0;
    run_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 0, 32'h12345678,
            g_rdata, g_be, g_addr, g_wdata, g_wen, g_err, g_rsp, g_req, g_stall);
    chk("t6_rdata", g_rdata, 32'h12345678);
    chk("t6_lat", g_rsp, 2);

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
